// File: rtl/conv_weight_streamer_1x1_pkg.sv
// Shared definitions for the 1x1 conv weight streamer: default sizes,
// FSM state encoding and a width helper used to size counters.
package conv_weight_streamer_1x1_pkg;

  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_CHANNEL_NUM_IN  = 128;
  localparam int DEF_CHANNEL_NUM_OUT = 256;
  localparam int DEF_KERNEL          = 1;
  localparam int DEF_NUM_PASSES      = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } stream_state_e;

  // Bit width needed to count 0..n-1; never narrower than one bit.
  function automatic int cw_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/conv_weight_addr_gen.sv
// Linear read-address and pass counter. addr is the next address to read;
// last flags the final address of the final pass.
module conv_weight_addr_gen
  import conv_weight_streamer_1x1_pkg::*;
#(
  parameter int TOTAL      = 128,
  parameter int NUM_PASSES = 1,
  parameter int ADDR_WIDTH = cw_width(TOTAL),
  parameter int PASS_WIDTH = cw_width(NUM_PASSES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(TOTAL - 1);
  localparam logic [PASS_WIDTH-1:0] PASS_LAST = PASS_WIDTH'(NUM_PASSES - 1);

  logic [ADDR_WIDTH-1:0] addr_r;
  logic [PASS_WIDTH-1:0] pass_r;
  logic                  wrap_s;

  assign wrap_s = (addr_r == ADDR_LAST);
  assign addr   = addr_r;
  assign last   = wrap_s && (pass_r == PASS_LAST);

  // Step through the weight set; wrap to address 0 and bump the pass count.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      addr_r <= '0;
      pass_r <= '0;
    end else if (advance) begin
      if (wrap_s) begin
        addr_r <= '0;
        pass_r <= pass_r + PASS_WIDTH'(1);
      end else begin
        addr_r <= addr_r + ADDR_WIDTH'(1);
        pass_r <= pass_r;
      end
    end else begin
      addr_r <= addr_r;
      pass_r <= pass_r;
    end
  end

endmodule

// File: rtl/conv_weight_streamer_1x1.sv
// Streams the stored 1x1 conv weight set from a synchronous memory as a
// valid-qualified word stream. Read strobe to output latency is 2 cycles.
module conv_weight_streamer_1x1
  import conv_weight_streamer_1x1_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int CHANNEL_NUM_OUT = DEF_CHANNEL_NUM_OUT,
  parameter int KERNEL          = DEF_KERNEL,
  parameter int NUM_PASSES      = DEF_NUM_PASSES,
  parameter int ADDR_WIDTH      = cw_width(KERNEL * KERNEL * CHANNEL_NUM_IN * CHANNEL_NUM_OUT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] weight_out,
  output logic                  valid_weight_out,
  output logic                  busy,
  output logic                  done
);

  localparam int TOTAL = KERNEL * KERNEL * CHANNEL_NUM_IN * CHANNEL_NUM_OUT;

  stream_state_e         state_r;
  stream_state_e         state_s;
  logic                  issue_s;
  logic                  clear_s;
  logic [ADDR_WIDTH-1:0] gen_addr_s;
  logic                  gen_last_s;

  logic                  mem_rd_en_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] weight_out_r;
  logic                  valid_out_r;
  logic                  busy_r;
  logic                  done_r;

  conv_weight_addr_gen #(
    .TOTAL      (TOTAL),
    .NUM_PASSES (NUM_PASSES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear_s),
    .advance (issue_s),
    .addr    (gen_addr_s),
    .last    (gen_last_s)
  );

  // Next-state and read-issue decision; the first read follows the start cycle.
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    clear_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          issue_s = 1'b1;
          state_s = gen_last_s ? ST_DRAIN : ST_STREAM;
        end else begin
          clear_s = 1'b1;
          state_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!pause) begin
          issue_s = 1'b1;
          state_s = gen_last_s ? ST_DRAIN : ST_STREAM;
        end else begin
          state_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        clear_s = 1'b1;
        if (!mem_rd_en_r && !s1_valid_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        clear_s = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        clear_s = 1'b1;
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered memory read port; the address holds while no read is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_en_r <= 1'b0;
      mem_addr_r  <= '0;
    end else begin
      mem_rd_en_r <= issue_s;
      mem_addr_r  <= issue_s ? gen_addr_s : mem_addr_r;
    end
  end

  // Two-stage valid pipeline: data returns one cycle after the strobe and
  // is registered onto weight_out the cycle after that.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_r   <= 1'b0;
      valid_out_r  <= 1'b0;
      weight_out_r <= '0;
    end else begin
      s1_valid_r   <= mem_rd_en_r;
      valid_out_r  <= s1_valid_r;
      weight_out_r <= s1_valid_r ? mem_rd_data : weight_out_r;
    end
  end

  // Status flags follow the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state_s == ST_STREAM) || (state_s == ST_DRAIN);
      done_r <= (state_s == ST_DONE);
    end
  end

  assign mem_rd_en        = mem_rd_en_r;
  assign mem_addr         = mem_addr_r;
  assign weight_out       = weight_out_r;
  assign valid_weight_out = valid_out_r;
  assign busy             = busy_r;
  assign done             = done_r;

endmodule

// File: tb/tb_conv_weight_streamer_1x1.sv
// Bench for conv_weight_streamer_1x1: two instances (1 pass and 2 passes),
// each with a memory holding mem[i] = i + 100, checked every cycle against
// a run-level model plus a few hand-computed cycle expectations.
module tb_conv_weight_streamer_1x1;

  localparam int CIN   = 4;
  localparam int COUT  = 2;
  localparam int TOTAL = CIN * COUT;

  logic        clk;
  logic        reset;
  logic        start0, start1;
  logic        pause;
  logic        rd_en0, rd_en1;
  logic [2:0]  addr0, addr1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] wout0, wout1;
  logic        vout0, vout1;
  logic        busy0, busy1;
  logic        done0, done1;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int scen    = 0;
  logic checking = 1'b0;

  // model state, indexed by instance
  logic        m_rd[2]   = '{1'b0, 1'b0};
  logic [2:0]  m_addr[2] = '{3'd0, 3'd0};
  logic        m_s1[2]   = '{1'b0, 1'b0};
  logic [2:0]  m_s1a[2]  = '{3'd0, 3'd0};
  logic        m_v[2]    = '{1'b0, 1'b0};
  logic [31:0] m_w[2]    = '{32'd0, 32'd0};
  logic        m_done[2] = '{1'b0, 1'b0};
  logic        run[2]    = '{1'b0, 1'b0};
  int          left[2]   = '{0, 0};
  int          outs[2]   = '{0, 0};
  int          idx[2]    = '{0, 0};
  int          t0[2]     = '{-1000, -1000};

  conv_weight_streamer_1x1 #(
    .DATA_WIDTH(32), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT),
    .KERNEL(1), .NUM_PASSES(1)
  ) dut0 (
    .clk(clk), .reset(reset), .start(start0), .pause(pause),
    .mem_rd_en(rd_en0), .mem_addr(addr0), .mem_rd_data(rdata0),
    .weight_out(wout0), .valid_weight_out(vout0), .busy(busy0), .done(done0)
  );

  conv_weight_streamer_1x1 #(
    .DATA_WIDTH(32), .CHANNEL_NUM_IN(CIN), .CHANNEL_NUM_OUT(COUT),
    .KERNEL(1), .NUM_PASSES(2)
  ) dut1 (
    .clk(clk), .reset(reset), .start(start1), .pause(pause),
    .mem_rd_en(rd_en1), .mem_addr(addr1), .mem_rd_data(rdata1),
    .weight_out(wout1), .valid_weight_out(vout1), .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memories; unread cycles return an obviously wrong word.
  always_ff @(posedge clk) begin
    rdata0 <= rd_en0 ? (32'd100 + {29'd0, addr0}) : (32'hBAD0_0000 | {29'd0, addr0});
    rdata1 <= rd_en1 ? (32'd100 + {29'd0, addr1}) : (32'hBAD0_0000 | {29'd0, addr1});
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle compare and model update.
  initial begin : compare_proc
    logic        a_rd, a_v, a_b, a_d, a_st;
    logic [2:0]  a_addr;
    logic [31:0] a_w;
    logic        n_done, acc;
    int          rel;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (i == 0) begin
          a_rd = rd_en0; a_addr = addr0; a_w = wout0; a_v = vout0;
          a_b = busy0; a_d = done0; a_st = start0;
        end else begin
          a_rd = rd_en1; a_addr = addr1; a_w = wout1; a_v = vout1;
          a_b = busy1; a_d = done1; a_st = start1;
        end
        if (checking) begin
          chk($sformatf("rd_en[%0d]@%0d", i, cyc), 32'(a_rd), 32'(m_rd[i]));
          chk($sformatf("addr[%0d]@%0d", i, cyc), 32'(a_addr), 32'(m_addr[i]));
          chk($sformatf("valid[%0d]@%0d", i, cyc), 32'(a_v), 32'(m_v[i]));
          chk($sformatf("weight[%0d]@%0d", i, cyc), a_w, m_w[i]);
          chk($sformatf("busy[%0d]@%0d", i, cyc), 32'(a_b), 32'(run[i]));
          chk($sformatf("done[%0d]@%0d", i, cyc), 32'(a_d), 32'(m_done[i]));
          rel = cyc - t0[i];
          if (i == 0 && scen == 1) begin
            if (rel == 1) chk("lit_basic_first_addr", {28'd0, a_rd, a_addr}, 32'd8);
            if (rel == 8) chk("lit_basic_last_addr", {28'd0, a_rd, a_addr}, 32'd15);
            if (rel == 2) chk("lit_basic_no_early_valid", 32'(a_v), 32'd0);
            if (rel == 3) chk("lit_basic_first_word", a_v ? a_w : 32'd0, 32'd100);
            if (rel == 10) chk("lit_basic_last_word", a_v ? a_w : 32'd0, 32'd107);
            if (rel == 11) chk("lit_basic_done", {30'd0, a_d, a_b}, 32'd2);
          end
          if (i == 0 && scen == 2) begin
            if (rel == 2) chk("lit_pause_addr1", {28'd0, a_rd, a_addr}, 32'd9);
            if (rel == 3) chk("lit_pause_stall", 32'(a_rd), 32'd0);
            if (rel == 6) chk("lit_pause_resume", {28'd0, a_rd, a_addr}, 32'd10);
            if (rel == 13) chk("lit_pause_last_word", a_v ? a_w : 32'd0, 32'd107);
            if (rel == 14) chk("lit_pause_done", 32'(a_d), 32'd1);
          end
          if (i == 1 && scen == 3) begin
            if (rel == 10) chk("lit_pass2_end_first", a_v ? a_w : 32'd0, 32'd107);
            if (rel == 11) chk("lit_pass2_wrap", a_v ? a_w : 32'd0, 32'd100);
            if (rel == 18) chk("lit_pass2_last", a_v ? a_w : 32'd0, 32'd107);
            if (rel == 19) chk("lit_pass2_done", 32'(a_d), 32'd1);
          end
          if (i == 0 && scen == 4 && rel == 11) chk("lit_busy_start_done", 32'(a_d), 32'd1);
          if (i == 0 && scen == 5 && rel == 6)
            chk("lit_reset_clear", {29'd0, a_v, a_b, a_rd}, 32'd0);
          if (i == 0 && scen == 7) begin
            if (rel == 3) chk("lit_restart_first", a_v ? a_w : 32'd0, 32'd100);
            if (rel == 10) chk("lit_restart_last", a_v ? a_w : 32'd0, 32'd107);
          end
          if (i == 0 && scen == 6 && rel == 11) chk("lit_drain_pause_done", 32'(a_d), 32'd1);
        end
        // model: derive next cycle's outputs from this cycle's inputs
        if (reset) begin
          m_rd[i] = 1'b0; m_addr[i] = 3'd0; m_s1[i] = 1'b0; m_s1a[i] = 3'd0;
          m_v[i] = 1'b0; m_w[i] = 32'd0; m_done[i] = 1'b0; run[i] = 1'b0;
          left[i] = 0; outs[i] = 0;
        end else begin
          acc = !run[i] && !m_done[i] && a_st;
          n_done = 1'b0;
          if (run[i] && m_v[i]) begin
            outs[i] = outs[i] - 1;
            if (outs[i] == 0) begin
              run[i] = 1'b0;
              n_done = 1'b1;
            end
          end
          m_w[i]   = m_s1[i] ? (32'd100 + {29'd0, m_s1a[i]}) : m_w[i];
          m_v[i]   = m_s1[i];
          m_s1[i]  = m_rd[i];
          m_s1a[i] = m_addr[i];
          m_done[i] = n_done;
          if (acc) begin
            run[i]  = 1'b1;
            left[i] = TOTAL * (i + 1);
            outs[i] = TOTAL * (i + 1);
            idx[i]  = 0;
            t0[i]   = cyc;
          end
          if (run[i] && left[i] > 0 && (acc || !pause)) begin
            m_rd[i]   = 1'b1;
            m_addr[i] = 3'(idx[i] % TOTAL);
            idx[i]    = idx[i] + 1;
            left[i]   = left[i] - 1;
          end else begin
            m_rd[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; pause = 1'b0;
    tick(1);
    checking = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    // basic single pass
    scen = 1; start0 = 1'b1; tick(1); start0 = 1'b0; tick(15);
    // pause so the strobe gap covers run cycles 3..5
    scen = 2; start0 = 1'b1; tick(1); start0 = 1'b0; tick(1);
    pause = 1'b1; tick(3); pause = 1'b0; tick(16);
    // two passes on the second instance
    scen = 3; start1 = 1'b1; tick(1); start1 = 1'b0; tick(23);
    // start while busy, start coincident with done, then start in idle
    scen = 4; start0 = 1'b1; tick(1); start0 = 1'b0; tick(3);
    start0 = 1'b1; tick(1); start0 = 1'b0; tick(6);
    start0 = 1'b1; tick(2); start0 = 1'b0; tick(15);
    // reset in the middle of a run
    scen = 5; start0 = 1'b1; tick(1); start0 = 1'b0; tick(4);
    reset = 1'b1; tick(1); reset = 1'b0; tick(12);
    // fresh run after the reset
    scen = 7; start0 = 1'b1; tick(1); start0 = 1'b0; tick(15);
    // start held several cycles, pause in the start cycle and through drain
    scen = 6; start0 = 1'b1; pause = 1'b1; tick(1); pause = 1'b0; tick(3);
    start0 = 1'b0; tick(4); pause = 1'b1; tick(8); pause = 1'b0; tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
